// File: rtl/arilla_bus_arbiter_if.sv
// Arbitration bundle for the shared arilla bus: per-master requests/locks in,
// one-hot grant and status out.
interface arilla_bus_arbiter_if #(
    parameter int NumMasters = 2
);
    localparam int IdW = (NumMasters > 1) ? $clog2(NumMasters) : 1;

    logic [NumMasters-1:0] req;
    logic [NumMasters-1:0] lock;
    logic [NumMasters-1:0] available;
    logic [IdW-1:0]        grant_id;
    logic                  contended;
    logic                  lock_error;

    modport master (
        output req,
        output lock,
        input  available,
        input  grant_id,
        input  contended,
        input  lock_error
    );

    modport slave (
        input  req,
        input  lock,
        output available,
        output grant_id,
        output contended,
        output lock_error
    );
endinterface

// File: rtl/arilla_bus_arbiter.sv
// Round-robin arbiter for the arilla bus: parks on the last owner, limits
// contended hold time and releases stuck locks through a watchdog.
module arilla_bus_arbiter #(
    parameter int NumMasters    = 2,
    parameter int DefaultMaster = 0,
    parameter int MaxHold       = 4,
    parameter int LockTimeout   = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    arilla_bus_arbiter_if.slave bus
);
    localparam int IdW   = (NumMasters > 1) ? $clog2(NumMasters) : 1;
    localparam int HoldW = $clog2(MaxHold + 1);
    localparam int LockW = $clog2(LockTimeout + 1);

    localparam logic [IdW-1:0]        DefId    = IdW'(DefaultMaster);
    localparam logic [NumMasters-1:0] OneHot0  = NumMasters'(1);
    localparam logic [HoldW-1:0]      HoldLast = HoldW'(MaxHold - 1);
    localparam logic [HoldW-1:0]      HoldMax  = HoldW'(MaxHold);
    localparam logic [LockW-1:0]      LockLast = LockW'(LockTimeout - 1);

    typedef enum logic [1:0] {
        ST_PARK   = 2'd0,
        ST_OWN    = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [IdW-1:0]        grant_q, grant_d;
    logic [NumMasters-1:0] avail_q, avail_d;
    logic [HoldW-1:0]      hold_q, hold_d;
    logic [LockW-1:0]      lock_cnt_q, lock_cnt_d;
    logic                  lock_err_q, lock_err_d;

    logic [NumMasters-1:0] waiting_s;
    logic                  contended_s;
    logic                  own_req_s;
    logic                  own_lock_s;
    logic [IdW-1:0]        next_waiter_s;
    logic                  found_s;
    logic                  switch_s;
    logic                  forced_s;

    assign waiting_s   = bus.req & ~avail_q;
    assign contended_s = |waiting_s;
    assign own_req_s   = bus.req[grant_q];
    assign own_lock_s  = bus.lock[grant_q];

    assign bus.available  = avail_q;
    assign bus.grant_id   = grant_q;
    assign bus.contended  = contended_s;
    assign bus.lock_error = lock_err_q;

    // Round-robin scan: first waiter after the owner, wrapping at NumMasters.
    always_comb begin
        next_waiter_s = grant_q;
        found_s       = 1'b0;
        for (int i = 1; i < NumMasters; i++) begin
            if (!found_s && waiting_s[IdW'((int'(grant_q) + i) % NumMasters)]) begin
                next_waiter_s = IdW'((int'(grant_q) + i) % NumMasters);
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-owner priority: lock, lock watchdog, hold limit, round-robin, park.
    always_comb begin
        switch_s = 1'b0;
        forced_s = 1'b0;
        if (own_lock_s) begin
            // An expired lock with nobody waiting has nobody to hand over to.
            if ((lock_cnt_q == LockLast) && contended_s) begin
                switch_s = 1'b1;
                forced_s = 1'b1;
            end else begin
                switch_s = 1'b0;
            end
        end else if (own_req_s && (!contended_s || (hold_q < HoldLast))) begin
            switch_s = 1'b0;
        end else if (contended_s) begin
            switch_s = 1'b1;
        end else begin
            switch_s = 1'b0;
        end
    end

    // Grant, counter and error next-state.
    always_comb begin
        grant_d    = grant_q;
        avail_d    = avail_q;
        hold_d     = hold_q;
        lock_cnt_d = lock_cnt_q;
        lock_err_d = forced_s;
        if (switch_s) begin
            grant_d    = next_waiter_s;
            avail_d    = OneHot0 << next_waiter_s;
            hold_d     = {HoldW{1'b0}};
            lock_cnt_d = {LockW{1'b0}};
        end else begin
            if (!contended_s) begin
                hold_d = {HoldW{1'b0}};
            end else if (own_req_s && (hold_q != HoldMax)) begin
                hold_d = hold_q + HoldW'(1);
            end else begin
                hold_d = hold_q;
            end
            if (own_lock_s && contended_s) begin
                lock_cnt_d = lock_cnt_q + LockW'(1);
            end else begin
                lock_cnt_d = {LockW{1'b0}};
            end
        end
    end

    // Ownership FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PARK, ST_OWN, ST_LOCKED: begin
                if (switch_s) begin
                    state_d = ST_OWN;
                end else if (own_lock_s) begin
                    state_d = ST_LOCKED;
                end else if (own_req_s) begin
                    state_d = ST_OWN;
                end else begin
                    state_d = ST_PARK;
                end
            end
            default: state_d = ST_PARK;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_PARK;
            grant_q    <= DefId;
            avail_q    <= OneHot0 << DefId;
            hold_q     <= {HoldW{1'b0}};
            lock_cnt_q <= {LockW{1'b0}};
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            avail_q    <= avail_d;
            hold_q     <= hold_d;
            lock_cnt_q <= lock_cnt_d;
            lock_err_q <= lock_err_d;
        end
    end
endmodule

// File: doc/arilla_bus_arbiter.md
# arilla_bus_arbiter

Round-robin arbiter for the shared arilla bus, directly upstream of each master's memory interface. It drives each master's `available` input. A master's memory interface drives the bus only while its `available` is high, and completes a write, or issues a read, in any cycle where `available` and its access request are both high. The arbiter parks the grant on the last owner, enforces a fairness hold limit, and supports per-master bus locking with a lock watchdog.

## Interface
- `NumMasters`, default 2: number of bus masters; must be 2–8.
- `DefaultMaster`, default 0: owner granted out of reset.
- `MaxHold`, default 4: maximum consecutive contended cycles one owner keeps the grant; must be ≥1.
- `LockTimeout`, default 64: maximum consecutive cycles a lock may hold the grant while others wait; must be ≥2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req`  in  NumMasters  per-master access request (the master's rd|wr).
- `lock`  in  NumMasters  per-master lock request; honoured only for the current owner.
- `available`  out  NumMasters  one-hot grant, registered.
- `grant_id`  out  $clog2(NumMasters)  index of the current owner, registered.
- `contended`  out  1  combinational; high when any non-owner has `req` high.
- `lock_error`  out  1  registered; one-cycle pulse when the lock watchdog forces a release.

## Operation
- Owner o = `grant_id`. `available` is always exactly one-hot and equals 1<<o.
- Waiting set W = `req` & ~`available`. `contended` = |W.
- `hold_cnt`:
  - Width $clog2(MaxHold+1).
  - Increments in each cycle where `contended` is high and `req[o]` is high.
  - Clears on any owner change, and in any cycle with `contended` low.
- `lock_cnt`:
  - Width $clog2(LockTimeout+1).
  - Increments in each cycle where `lock[o]` and `contended` are both high.
  - Clears otherwise, and on owner change.
- Next-owner decision, evaluated every cycle in strict priority order:
  1. `lock[o]` high and `lock_cnt` < LockTimeout-1: keep o.
  2. `lock[o]` high and `lock_cnt` == LockTimeout-1: switch to the next waiter; pulse `lock_error` next cycle.
  3. `req[o]` high and (`contended` low or `hold_cnt` < MaxHold-1): keep o.
  4. `contended` high: switch to the first set bit of W, scanning (o+1) mod N, (o+2) mod N, … (round-robin).
  5. Otherwise: keep o (park on last owner).
- FSM states:
  - PARK: owner not requesting.
  - OWN: owner requesting, no lock.
  - LOCKED: `lock[o]` high.
- FSM transitions:
  - Any state → OWN (new owner) on a switch.
  - OWN ↔ LOCKED follows `lock[o]`.
  - OWN → PARK when `req[o]` falls with `contended` low.
- `lock` of a non-owner is ignored. After a forced release, that master re-enters the round-robin like any other requester.
- Read data returns on the dedicated `data_in` path one cycle after the read and is latched by the issuing interface. A grant switch in the cycle after a read is therefore legal; no turnaround cycle is inserted.

## Timing
- Reset values:
  - `available` = 1<<DefaultMaster.
  - `grant_id` = DefaultMaster.
  - `lock_error` = 0.
  - `hold_cnt` = 0, `lock_cnt` = 0, FSM = PARK.
- Reset asserted mid-operation: all of the above are restored on the next rising edge, regardless of `req`/`lock`.
- Owner already requesting: zero-latency access (same cycle).
- Non-owner request arriving at cycle t, owner idle: `available` moves at t+1. First access at t+1.
- Contended owner keeps the grant for exactly MaxHold consecutive cycles, then loses it on the following edge.
- `req` of owner and waiter both fall in the same cycle: park on o, no switch.
- `grant_id` wraps from N-1 to 0 in the round-robin scan.
- Simultaneous `lock` rise and watchdog expiry cannot occur: the watchdog counts only while `lock[o]` is high.
- `lock_error` asserts the cycle the new `available` appears, for exactly one cycle.

## Test plan
- Reset, `req`=00 for 5 cycles: `available`=01, `grant_id`=0, `lock_error`=0 throughout.
- `req`=10 from cycle 2: `available`=10 at cycle 3. `req`→00: `available` stays 10 (parked).
- `req`=11 continuously, owner 0, MaxHold=4: `available` alternates 01 ×4 cycles, 10 ×4 cycles, 01 ×4 …
- N=3, owner 0, `req`=111 with 0 hold expiring: grant goes to 1, then 2, then 0 (wrap-around).
- Owner 0 with `lock`=01, `req`=11, LockTimeout=64: `available`=01 for 64 cycles, then 10, with `lock_error` high exactly one cycle coincident with the switch. Master 1's `lock`, while not owner, has no effect.
- `rst_n` low for one cycle while owner 1 is locked with `hold_cnt`=3: next cycle `available`=01, counters 0, `lock_error`=0.
